// File: rtl/md_controller.sv
// HI/LO multiply-divide controller: sequences the shared 32x32 multiplier for EX,
// owns the architectural HI/LO registers and stalls the pipeline on HI/LO hazards.
module md_controller #(
  parameter int MUL_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Is_signed,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  input  logic        MfReq,
  input  logic        MfSel,
  input  logic        MtWe,
  input  logic [31:0] MtData,
  input  logic [63:0] Mul_s,
  output logic        Mul_start,
  output logic [31:0] Mul_a,
  output logic [31:0] Mul_b,
  output logic        Mul_signed,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] MfData,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               signed_q, signed_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    signed_d  = signed_q;
    Mul_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Start wins over a simultaneous mthi/mtlo.
        if (Start && !Flush) begin
          a_d      = A;
          b_d      = B;
          signed_d = Is_signed;
          state_d  = ISSUE;
        end else if (MtWe && !Flush) begin
          if (MfSel) hi_d = MtData;
          else       lo_d = MtData;
        end
      end
      ISSUE: begin
        Mul_start = 1'b1;
        cnt_d     = CNT_INIT;
        state_d   = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          hi_d    = Mul_s[63:32];
          lo_d    = Mul_s[31:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Any HI/LO access or new multiply while one is in flight must wait.
  assign Busy       = (state_q != IDLE);
  assign Stall      = Busy & (Start | MfReq | MtWe) & ~Flush;
  assign MfData     = MfSel ? hi_q : lo_q;
  assign Hi         = hi_q;
  assign Lo         = lo_q;
  assign Mul_a      = a_q;
  assign Mul_b      = b_q;
  assign Mul_signed = signed_q;

endmodule

// File: tb/tb_md_controller.sv
// Directed bench for md_controller: one instance at MUL_LAT=1 and one at MUL_LAT=3
// share the stimulus; each is fed by its own behavioural multiplier.
module tb_md_controller;

  logic        Clk = 1'b0;
  logic        Reset, Start, Is_signed, Flush, MfReq, MfSel, MtWe;
  logic [31:0] A, B, MtData;

  logic [63:0] mul_s1, mul_s3;
  logic        mul_start1, mul_start3, mul_signed1, mul_signed3;
  logic [31:0] mul_a1, mul_b1, mul_a3, mul_b3;
  logic        busy1, busy3, stall1, stall3;
  logic [31:0] mfdata1, mfdata3, hi1, hi3, lo1, lo3;

  int checks = 0;
  int errors = 0;
  int pulses1 = 0;
  int pulses3 = 0;
  int snap;

  always #5 Clk = ~Clk;

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  assign mul_s1 = mul_model(mul_a1, mul_b1, mul_signed1);
  assign mul_s3 = mul_model(mul_a3, mul_b3, mul_signed3);

  always @(posedge Clk) begin
    if (mul_start1 === 1'b1) pulses1++;
    if (mul_start3 === 1'b1) pulses3++;
  end

  md_controller #(.MUL_LAT(1), .CNT_W(4)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Is_signed(Is_signed), .A(A), .B(B),
    .Flush(Flush), .MfReq(MfReq), .MfSel(MfSel), .MtWe(MtWe), .MtData(MtData),
    .Mul_s(mul_s1), .Mul_start(mul_start1), .Mul_a(mul_a1), .Mul_b(mul_b1),
    .Mul_signed(mul_signed1), .Busy(busy1), .Stall(stall1), .MfData(mfdata1),
    .Hi(hi1), .Lo(lo1)
  );

  md_controller #(.MUL_LAT(3), .CNT_W(4)) dut3 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Is_signed(Is_signed), .A(A), .B(B),
    .Flush(Flush), .MfReq(MfReq), .MfSel(MfSel), .MtWe(MtWe), .MtData(MtData),
    .Mul_s(mul_s3), .Mul_start(mul_start3), .Mul_a(mul_a3), .Mul_b(mul_b3),
    .Mul_signed(mul_signed3), .Busy(busy3), .Stall(stall3), .MfData(mfdata3),
    .Hi(hi3), .Lo(lo3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs set afterwards apply to this cycle.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Start = 0; Is_signed = 0; A = '0; B = '0; Flush = 0;
    MfReq = 0; MfSel = 0; MtWe = 0; MtData = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1;
    tick();
    tick();
    Reset = 0;
  endtask

  initial begin
    Reset = 1;
    idle_inputs();

    // Reset held for two cycles
    do_reset();
    #1;
    check("rst_busy",  busy1, 0);
    check("rst_stall", stall1, 0);
    check("rst_start", mul_start1, 0);
    check("rst_hi",    hi1, 0);
    check("rst_lo",    lo1, 0);
    check("rst_mula",  mul_a1, 0);
    check("rst_sgn",   mul_signed1, 0);
    check("rst_busy3", busy3, 0);

    // 7 x 6 unsigned, MUL_LAT=1
    Start = 1; A = 32'd7; B = 32'd6; Is_signed = 0;      // cycle 0
    #1 check("c0_busy", busy1, 0);
    tick(); Start = 0;                                   // cycle 1
    #1 check("c1_mulstart", mul_start1, 1);
    check("c1_busy", busy1, 1);
    check("c1_mula", mul_a1, 7);
    check("c1_mulb", mul_b1, 6);
    tick();                                              // cycle 2
    #1 check("c2_mulstart", mul_start1, 0);
    check("c2_busy", busy1, 1);
    check("c2_lo_old", lo1, 0);
    tick();                                              // cycle 3
    #1 check("c3_busy", busy1, 0);
    check("c3_lo", lo1, 32'h0000002A);
    check("c3_hi", hi1, 0);

    // 0x10000 squared with mfhi stalled behind it
    do_reset();
    Start = 1; A = 32'h00010000; B = 32'h00010000;       // cycle 0
    tick(); Start = 0; MfReq = 1; MfSel = 1;             // cycle 1
    #1 check("mf_stall1", stall1, 1);
    tick();                                              // cycle 2
    #1 check("mf_stall2", stall1, 1);
    tick();                                              // cycle 3
    #1 check("mf_stall3", stall1, 0);
    check("mf_data_hi", mfdata1, 32'h00000001);
    check("sq_lo", lo1, 0);
    MfSel = 0;
    #1 check("mf_data_lo", mfdata1, 32'h00000000);
    MfReq = 0;

    // Signed: -2 x 3
    do_reset();
    Start = 1; A = 32'hFFFFFFFE; B = 32'd3; Is_signed = 1;
    tick(); Start = 0; Is_signed = 0;
    #1 check("sg_flag", mul_signed1, 1);
    tick(); tick();
    #1 check("sg_hi", hi1, 32'hFFFFFFFF);
    check("sg_lo", lo1, 32'hFFFFFFFA);

    // Back-to-back on MUL_LAT=3 with Start held
    do_reset();
    snap = pulses3;
    Start = 1; A = 32'd5; B = 32'd5;                     // cycle 0
    tick(); A = 32'd3; B = 32'd4;                        // cycle 1
    #1 check("bb_c1_start", mul_start3, 1);
    check("bb_c1_stall", stall3, 1);
    tick(); tick(); tick();                              // cycle 4
    #1 check("bb_c4_busy", busy3, 1);
    check("bb_c4_stall", stall3, 1);
    check("bb_c4_lo", lo3, 0);
    tick();                                              // cycle 5
    #1 check("bb_c5_busy", busy3, 0);
    check("bb_c5_stall", stall3, 0);
    check("bb_c5_lo", lo3, 25);
    tick(); Start = 0;                                   // cycle 6
    #1 check("bb_c6_start", mul_start3, 1);
    check("bb_c6_mula", mul_a3, 3);
    tick(); tick(); tick();                              // cycle 9
    #1 check("bb_c9_busy", busy3, 1);
    check("bb_c9_lo", lo3, 25);
    tick();                                              // cycle 10
    #1 check("bb_c10_lo", lo3, 12);
    check("bb_c10_busy", busy3, 0);
    check("bb_pulses", pulses3 - snap, 2);

    // mtlo issued while busy: commit first, then the write
    do_reset();
    Start = 1; A = 32'd7; B = 32'd6;                     // cycle 0
    tick(); Start = 0; MtWe = 1; MfSel = 0; MtData = 32'hDEADBEEF;
    #1 check("mt_stall1", stall1, 1);
    tick();
    #1 check("mt_stall2", stall1, 1);
    tick();                                              // cycle 3
    #1 check("mt_stall3", stall1, 0);
    check("mt_commit_lo", lo1, 32'h0000002A);
    tick(); MtWe = 0;                                    // cycle 4
    #1 check("mt_lo", lo1, 32'hDEADBEEF);
    check("mt_hi", hi1, 0);

    // Start squashed by Flush in IDLE
    snap = pulses1;
    Start = 1; Flush = 1; A = 32'd9; B = 32'd9;
    #1 check("fl_stall", stall1, 0);
    tick(); Start = 0; Flush = 0;
    #1 check("fl_busy", busy1, 0);
    check("fl_mula", mul_a1, 7);
    tick();
    #1 check("fl_pulses", pulses1 - snap, 0);
    check("fl_lo", lo1, 32'hDEADBEEF);

    // Flush during WAIT on MUL_LAT=3 does not cancel the commit
    do_reset();
    Start = 1; A = 32'd2; B = 32'd5;                     // cycle 0
    tick(); Start = 0;                                   // cycle 1
    tick(); Flush = 1;                                   // cycle 2
    tick(); tick();                                      // cycle 4
    #1 check("flw_busy", busy3, 1);
    tick(); Flush = 0;                                   // cycle 5
    #1 check("flw_lo", lo3, 10);

    // Reset in the WAIT cycle of MUL_LAT=1 discards the product
    do_reset();
    Start = 1; A = 32'd7; B = 32'd6;                     // cycle 0
    tick(); Start = 0;                                   // cycle 1
    tick(); Reset = 1;                                   // cycle 2 (WAIT)
    #1 check("rw_mul_s", mul_s1, 64'd42);
    tick(); Reset = 0;                                   // cycle 3
    #1 check("rw_busy", busy1, 0);
    check("rw_hi", hi1, 0);
    check("rw_lo", lo1, 0);
    tick();
    #1 check("rw_lo_after", lo1, 0);
    check("rw_busy_after", busy1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
